// File: rtl/ctrl_tx_pkg.sv
// Shared definitions for the UART TX/RX controllers: default frame width and
// the TX sequencer state encoding.
package ctrl_tx_pkg;

  localparam int DEFAULT_WIDTH = 8;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_RF_LOAD  = 3'd1;
  localparam logic [2:0] ST_ALU_LOAD = 3'd2;
  localparam logic [2:0] ST_SEND_B0  = 3'd3;
  localparam logic [2:0] ST_WAIT_B0  = 3'd4;
  localparam logic [2:0] ST_SEND_B1  = 3'd5;
  localparam logic [2:0] ST_WAIT_B1  = 3'd6;

  typedef enum logic [2:0] {
    IDLE     = ST_IDLE,
    RF_LOAD  = ST_RF_LOAD,
    ALU_LOAD = ST_ALU_LOAD,
    SEND_B0  = ST_SEND_B0,
    WAIT_B0  = ST_WAIT_B0,
    SEND_B1  = ST_SEND_B1,
    WAIT_B1  = ST_WAIT_B1
  } tx_state_e;

endpackage

// File: rtl/ctrl_tx.sv
// ctrl_tx: sequences RF read bytes and ALU results into a byte-wide UART transmitter.
// Define CTRL_TX_MSB_FIRST_EN to send ALU results high byte first.
//
// state    | meaning
// IDLE     | nothing in flight; serve RF (pulse or pending) before ALU
// RF_LOAD  | capture RF byte, wait for transmitter free
// ALU_LOAD | capture ALU result, wait for transmitter free
// SEND_B0  | offer first byte until TX_BUSY rises
// WAIT_B0  | first byte shifting out
// SEND_B1  | offer second byte until TX_BUSY rises
// WAIT_B1  | second byte shifting out
module ctrl_tx
  import ctrl_tx_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               UART_RF_SEND,
  input  logic [WIDTH-1:0]   UART_SEND_RF_DATA,
  input  logic               UART_ALU_SEND,
  input  logic [2*WIDTH-1:0] UART_SEND_ALU_DATA,
  input  logic               TX_BUSY,
  output logic [WIDTH-1:0]   TX_P_DATA,
  output logic               TX_D_VLD,
  output logic               CTRL_TX_BUSY
);

  tx_state_e          state, state_nxt;
  logic [2*WIDTH-1:0] hold;
  logic               two_bytes;
  logic               pend_rf, pend_alu;
  logic               rf_cap_d, alu_cap_d;
  logic               ld_first;
  logic [WIDTH-1:0]   pend_rf_data;
  logic [2*WIDTH-1:0] pend_alu_data;
  logic               in_idle, rf_go, alu_go, rf_acc, alu_acc, rf_set, alu_set;
  logic               swap;
  logic [WIDTH-1:0]   byte0, byte1;

  assign in_idle = (state == IDLE);
  assign rf_go   = UART_RF_SEND | pend_rf;
  assign alu_go  = UART_ALU_SEND | pend_alu;
  // A pulse is accepted unless its source already has one waiting.
  assign rf_acc  = UART_RF_SEND & ~pend_rf;
  assign alu_acc = UART_ALU_SEND & ~pend_alu;
  assign rf_set  = rf_acc & ~in_idle;
  assign alu_set = alu_acc & ~(in_idle & ~rf_go);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (rf_go)       state_nxt = RF_LOAD;
        else if (alu_go) state_nxt = ALU_LOAD;
      end
      RF_LOAD, ALU_LOAD: if (!TX_BUSY) state_nxt = SEND_B0;
      SEND_B0:           if (TX_BUSY)  state_nxt = WAIT_B0;
      WAIT_B0:           if (!TX_BUSY) state_nxt = two_bytes ? SEND_B1 : IDLE;
      SEND_B1:           if (TX_BUSY)  state_nxt = WAIT_B1;
      WAIT_B1:           if (!TX_BUSY) state_nxt = IDLE;
      default:           state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state         <= IDLE;
      hold          <= '0;
      two_bytes     <= 1'b0;
      pend_rf       <= 1'b0;
      pend_alu      <= 1'b0;
      rf_cap_d      <= 1'b0;
      alu_cap_d     <= 1'b0;
      ld_first      <= 1'b0;
      pend_rf_data  <= '0;
      pend_alu_data <= '0;
    end else begin
      state     <= state_nxt;
      ld_first  <= in_idle & (rf_go | alu_go);
      rf_cap_d  <= rf_acc;
      alu_cap_d <= alu_acc;
      if (in_idle & rf_go)                pend_rf <= 1'b0;
      else if (rf_set)                    pend_rf <= 1'b1;
      if (in_idle & ~rf_go & alu_go)      pend_alu <= 1'b0;
      else if (alu_set)                   pend_alu <= 1'b1;
      if (rf_cap_d)  pend_rf_data  <= UART_SEND_RF_DATA;
      if (alu_cap_d) pend_alu_data <= UART_SEND_ALU_DATA;
      // Live bus only when the pulse was one cycle ago; otherwise it was parked.
      if (ld_first && state == RF_LOAD) begin
        hold      <= {{WIDTH{1'b0}}, (rf_cap_d ? UART_SEND_RF_DATA : pend_rf_data)};
        two_bytes <= 1'b0;
      end
      if (ld_first && state == ALU_LOAD) begin
        hold      <= alu_cap_d ? UART_SEND_ALU_DATA : pend_alu_data;
        two_bytes <= 1'b1;
      end
    end
  end

`ifdef CTRL_TX_MSB_FIRST_EN
  logic is_alu;
  always_ff @(posedge CLK) begin
    if (!RST)          is_alu <= 1'b0;
    else if (ld_first) is_alu <= (state == ALU_LOAD);
  end
  assign swap = is_alu;
`else
  assign swap = 1'b0;
`endif

  assign byte0 = swap ? hold[2*WIDTH-1:WIDTH] : hold[WIDTH-1:0];
  assign byte1 = swap ? hold[WIDTH-1:0] : hold[2*WIDTH-1:WIDTH];

  always_comb begin
    TX_D_VLD  = 1'b0;
    TX_P_DATA = '0;
    case (state)
      SEND_B0: begin TX_D_VLD = 1'b1; TX_P_DATA = byte0; end
      WAIT_B0: TX_P_DATA = byte0;
      SEND_B1: begin TX_D_VLD = 1'b1; TX_P_DATA = byte1; end
      WAIT_B1: TX_P_DATA = byte1;
      default: ;
    endcase
  end

  assign CTRL_TX_BUSY = ~in_idle | pend_rf | pend_alu;

endmodule

// File: tb/tb_ctrl_tx.sv
// Self-checking bench for ctrl_tx: directed table, hand sequences for timing
// corners, and randomized requests checked against a request-queue model.
module tb_ctrl_tx;
  import ctrl_tx_pkg::*;

  localparam int W = DEFAULT_WIDTH;
`ifdef CTRL_TX_MSB_FIRST_EN
  localparam bit MSB = 1'b1;
`else
  localparam bit MSB = 1'b0;
`endif

  logic           CLK = 1'b0;
  logic           RST = 1'b0;
  logic           UART_RF_SEND = 1'b0;
  logic           UART_ALU_SEND = 1'b0;
  logic [W-1:0]   UART_SEND_RF_DATA = '0;
  logic [2*W-1:0] UART_SEND_ALU_DATA = '0;
  logic           TX_BUSY;
  logic [W-1:0]   TX_P_DATA;
  logic           TX_D_VLD;
  logic           CTRL_TX_BUSY;

  logic auto_tx = 1'b0, tx_busy_auto = 1'b0, tx_busy_man = 1'b0;
  assign TX_BUSY = auto_tx ? tx_busy_auto : tx_busy_man;

  ctrl_tx #(.WIDTH(W)) dut (
    .CLK(CLK), .RST(RST),
    .UART_RF_SEND(UART_RF_SEND), .UART_SEND_RF_DATA(UART_SEND_RF_DATA),
    .UART_ALU_SEND(UART_ALU_SEND), .UART_SEND_ALU_DATA(UART_SEND_ALU_DATA),
    .TX_BUSY(TX_BUSY), .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD),
    .CTRL_TX_BUSY(CTRL_TX_BUSY)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int busy_len = 2;
  int vld_rises = 0;
  logic prev_vld = 1'b0;
  logic [W-1:0] got[$];

  // Each new TX_D_VLD assertion is one frame request; record its byte.
  always @(negedge CLK) begin
    if (TX_D_VLD && !prev_vld) begin
      got.push_back(TX_P_DATA);
      vld_rises++;
    end
    prev_vld = TX_D_VLD;
  end

  // UART transmitter model: busy one cycle after a request, for busy_len cycles.
  initial forever begin
    @(negedge CLK);
    if (auto_tx && TX_D_VLD && !tx_busy_auto) begin
      @(posedge CLK); #1 tx_busy_auto = 1'b1;
      repeat (busy_len) @(posedge CLK);
      #1 tx_busy_auto = 1'b0;
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK); #1;
  endtask

  task automatic scramble();
    UART_SEND_RF_DATA  = W'($urandom);
    UART_SEND_ALU_DATA = (2*W)'($urandom);
  endtask

  // Drives an initial request plus optional extra pulse, then waits until drained.
  task automatic run_txn(input bit rf, input logic [W-1:0] rfd, input bit alu,
                         input logic [2*W-1:0] alud, input int xsrc,
                         input logic [2*W-1:0] xd, input int xoff, input int n_exp,
                         output int gap, output bit tmo);
    int c;
    gap = 0;
    got.delete();
    for (int i = 0; i < 8; i++) begin
      step();
      UART_RF_SEND  = (i == 0 && rf)  || (xsrc == 1 && i == xoff);
      UART_ALU_SEND = (i == 0 && alu) || (xsrc == 2 && i == xoff);
      scramble();
      if (i == 1 && rf)                UART_SEND_RF_DATA  = rfd;
      if (i == 1 && alu)               UART_SEND_ALU_DATA = alud;
      if (xsrc == 1 && i == xoff + 1)  UART_SEND_RF_DATA  = xd[W-1:0];
      if (xsrc == 2 && i == xoff + 1)  UART_SEND_ALU_DATA = xd;
      @(negedge CLK);
      if (i > 0 && !CTRL_TX_BUSY && got.size() < n_exp) gap++;
    end
    c = 0;
    while (!(got.size() >= n_exp && !CTRL_TX_BUSY && !TX_BUSY) && c < 400) begin
      step();
      scramble();
      @(negedge CLK);
      if (!CTRL_TX_BUSY && got.size() < n_exp) gap++;
      c++;
    end
    tmo = (c >= 400);
    repeat (4) step();
  endtask

  task automatic cmp_bytes(input string name, input logic [W-1:0] exp[$]);
    chk({name, "_count"}, 32'(got.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      chk({name, "_byte"}, 32'(got[i]), 32'(exp[i]));
  endtask

  typedef struct {
    string          name;
    bit             rf;
    logic [W-1:0]   rfd;
    bit             alu;
    logic [2*W-1:0] alud;
    int             xsrc;
    logic [2*W-1:0] xd;
    int             xoff;
    int             n;
    logic [31:0]    b;   // first byte in [7:0]
  } vec_t;

  function automatic logic [31:0] pk(input logic [7:0] a, input logic [7:0] b,
                                     input logic [7:0] c, input logic [7:0] d);
    return {d, c, b, a};
  endfunction

  // Reference: current request served first, then pending RF, then pending ALU.
  function automatic void push_req(inout logic [W-1:0] q[$], input bit is_alu,
                                   input logic [2*W-1:0] d);
    if (!is_alu) q.push_back(d[W-1:0]);
    else if (MSB) begin q.push_back(d[2*W-1:W]); q.push_back(d[W-1:0]); end
    else          begin q.push_back(d[W-1:0]);   q.push_back(d[2*W-1:W]); end
  endfunction

  vec_t vt[8];
  logic [W-1:0] expq[$];
  int gap;
  bit tmo;
  int vr0;

  initial begin
    vt[0] = '{"rf_5a",    1, 8'h5A, 0, 16'h0000, 0, 16'h0000, 0, 1, pk(8'h5A, 0, 0, 0)};
    vt[1] = '{"alu_1234", 0, 8'h00, 1, 16'h1234, 0, 16'h0000, 0, 2,
              MSB ? pk(8'h12, 8'h34, 0, 0) : pk(8'h34, 8'h12, 0, 0)};
    vt[2] = '{"both",     1, 8'hA1, 1, 16'hBEEF, 0, 16'h0000, 0, 3,
              MSB ? pk(8'hA1, 8'hBE, 8'hEF, 0) : pk(8'hA1, 8'hEF, 8'hBE, 0)};
    vt[3] = '{"rf_x_alu", 1, 8'h3C, 0, 16'h0000, 2, 16'hC0DE, 2, 3,
              MSB ? pk(8'h3C, 8'hC0, 8'hDE, 0) : pk(8'h3C, 8'hDE, 8'hC0, 0)};
    vt[4] = '{"alu_x_rf", 0, 8'h00, 1, 16'h00FF, 1, 16'h0077, 1, 3,
              MSB ? pk(8'h00, 8'hFF, 8'h77, 0) : pk(8'hFF, 8'h00, 8'h77, 0)};
    vt[5] = '{"both_x_rf", 1, 8'h11, 1, 16'h2233, 1, 16'h0044, 3, 4,
              MSB ? pk(8'h11, 8'h44, 8'h22, 8'h33) : pk(8'h11, 8'h44, 8'h33, 8'h22)};
    vt[6] = '{"both_x_alu_drop", 1, 8'h55, 1, 16'h6677, 2, 16'h8899, 2, 3,
              MSB ? pk(8'h55, 8'h66, 8'h77, 0) : pk(8'h55, 8'h77, 8'h66, 0)};
    vt[7] = '{"rf_x_rf",  1, 8'h99, 0, 16'h0000, 1, 16'h00AA, 1, 2, pk(8'h99, 8'hAA, 0, 0)};

    // Reset state, with pulses presented during reset
    UART_RF_SEND = 1'b1; UART_ALU_SEND = 1'b1;
    repeat (3) step();
    @(negedge CLK);
    chk("rst_vld",  32'(TX_D_VLD), 32'd0);
    chk("rst_data", 32'(TX_P_DATA), 32'd0);
    chk("rst_busy", 32'(CTRL_TX_BUSY), 32'd0);
    step(); UART_RF_SEND = 1'b0; UART_ALU_SEND = 1'b0;
    step(); RST = 1'b1;
    repeat (3) step();
    @(negedge CLK);
    chk("post_rst_idle", 32'({CTRL_TX_BUSY, TX_D_VLD}), 32'd0);

    // RF latency and hold with transmitter idle
    step(); UART_RF_SEND = 1'b1; scramble();
    @(negedge CLK); chk("lat_c0_vld", 32'(TX_D_VLD), 32'd0);
    step(); UART_RF_SEND = 1'b0; UART_SEND_RF_DATA = 8'h5A;
    @(negedge CLK); chk("lat_c1_vld", 32'(TX_D_VLD), 32'd0);
    chk("lat_c1_busy", 32'(CTRL_TX_BUSY), 32'd1);
    step(); scramble();
    @(negedge CLK); chk("lat_c2_vld_data", 32'({TX_D_VLD, TX_P_DATA}), 32'h15A);
    for (int i = 0; i < 3; i++) begin
      step(); scramble();
      @(negedge CLK); chk("hold_vld_data", 32'({TX_D_VLD, TX_P_DATA}), 32'h15A);
    end
    step(); tx_busy_man = 1'b1;
    step();
    @(negedge CLK); chk("wait_vld_data", 32'({TX_D_VLD, TX_P_DATA}), 32'h05A);
    step(); tx_busy_man = 1'b0;
    step();
    @(negedge CLK); chk("done_idle", 32'({CTRL_TX_BUSY, TX_D_VLD, TX_P_DATA}), 32'd0);

    // RF request while transmitter stays busy for 20 cycles
    got.delete();
    step(); tx_busy_man = 1'b1; UART_RF_SEND = 1'b1; scramble();
    vr0 = vld_rises;
    step(); UART_RF_SEND = 1'b0; UART_SEND_RF_DATA = 8'hC3;
    for (int i = 0; i < 18; i++) begin step(); scramble(); end
    @(negedge CLK);
    chk("busy20_no_vld", 32'(vld_rises - vr0), 32'd0);
    step(); tx_busy_man = 1'b0;
    for (int i = 0; i < 5 && got.size() == 0; i++) @(negedge CLK);
    chk("busy20_sent", 32'(got.size()), 32'd1);
    if (got.size() > 0) chk("busy20_byte", 32'(got[0]), 32'hC3);
    step(); tx_busy_man = 1'b1;
    step(); tx_busy_man = 1'b0;
    repeat (3) step();

    // Reset during WAIT_B0 of an ALU transfer
    step(); UART_ALU_SEND = 1'b1; scramble();
    step(); UART_ALU_SEND = 1'b0; UART_SEND_ALU_DATA = 16'h1234;
    step(); scramble(); tx_busy_man = 1'b1;
    step();
    @(negedge CLK);
    chk("rstmid_wait_b0", 32'({TX_D_VLD, TX_P_DATA}), MSB ? 32'h012 : 32'h034);
    RST = 1'b0;
    step();
    @(negedge CLK);
    chk("rstmid_outputs", 32'({CTRL_TX_BUSY, TX_D_VLD, TX_P_DATA}), 32'd0);
    got.delete();
    step(); RST = 1'b1; tx_busy_man = 1'b0;
    repeat (10) step();
    chk("rstmid_no_b1", 32'(got.size()), 32'd0);

    // Directed table with the transmitter model in the loop
    auto_tx = 1'b1;
    busy_len = 3;
    foreach (vt[k]) begin
      run_txn(vt[k].rf, vt[k].rfd, vt[k].alu, vt[k].alud, vt[k].xsrc, vt[k].xd,
              vt[k].xoff, vt[k].n, gap, tmo);
      expq.delete();
      for (int i = 0; i < vt[k].n; i++) expq.push_back(vt[k].b[8*i +: 8]);
      chk({vt[k].name, "_timeout"}, 32'(tmo), 32'd0);
      chk({vt[k].name, "_busy_gap"}, 32'(gap), 32'd0);
      cmp_bytes(vt[k].name, expq);
    end

    // Three RF pulses during one ALU transfer: only the first survives
    busy_len = 6;
    got.delete();
    step(); UART_ALU_SEND = 1'b1; scramble();
    step(); UART_ALU_SEND = 1'b0; UART_SEND_ALU_DATA = 16'h1234;
    for (int i = 2; i < 8; i++) begin
      step(); scramble();
      UART_RF_SEND = (i == 2 || i == 4 || i == 6);
      if (i == 3) UART_SEND_RF_DATA = 8'h01;
      if (i == 5) UART_SEND_RF_DATA = 8'h02;
      if (i == 7) UART_SEND_RF_DATA = 8'h03;
    end
    step(); UART_RF_SEND = 1'b0; UART_SEND_RF_DATA = 8'h03;
    begin
      int c = 0;
      while (!(got.size() >= 3 && !CTRL_TX_BUSY && !TX_BUSY) && c < 300) begin
        step(); scramble(); @(negedge CLK); c++;
      end
      chk("drop3_timeout", 32'(c >= 300), 32'd0);
    end
    repeat (5) step();
    expq.delete();
    push_req(expq, 1'b1, 16'h1234);
    push_req(expq, 1'b0, 16'h0001);
    cmp_bytes("drop3", expq);

    // Randomized requests against the queue model
    for (int it = 0; it < 40; it++) begin
      int kind, xsrc, xoff;
      logic [W-1:0] rfd;
      logic [2*W-1:0] alud, xd;
      bit p_rf, p_alu;
      logic [2*W-1:0] p_rfd, p_alud;
      kind = $urandom_range(0, 2);
      xsrc = $urandom_range(0, 2);
      xoff = $urandom_range(1, 3);
      rfd  = W'($urandom);
      alud = (2*W)'($urandom);
      xd   = (2*W)'($urandom);
      busy_len = $urandom_range(1, 4);
      expq.delete();
      p_rf = 1'b0; p_alu = 1'b0; p_rfd = '0; p_alud = '0;
      if (kind == 1) push_req(expq, 1'b1, alud);
      else           push_req(expq, 1'b0, {{W{1'b0}}, rfd});
      if (kind == 2) begin p_alu = 1'b1; p_alud = alud; end
      if (xsrc == 1 && !p_rf)  begin p_rf = 1'b1;  p_rfd = xd; end
      if (xsrc == 2 && !p_alu) begin p_alu = 1'b1; p_alud = xd; end
      if (p_rf)  push_req(expq, 1'b0, {{W{1'b0}}, p_rfd[W-1:0]});
      if (p_alu) push_req(expq, 1'b1, p_alud);
      run_txn(kind != 1, rfd, kind != 0, alud, xsrc, xd, xoff, expq.size(), gap, tmo);
      chk("rnd_timeout", 32'(tmo), 32'd0);
      chk("rnd_busy_gap", 32'(gap), 32'd0);
      cmp_bytes("rnd", expq);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
